// File: rtl/dtpmod_pkg.sv
// Shared definitions for the DT PMOD dual-digit 7-segment display slice.
//   SEG_BLANK   : all segments off (segments are active low)
//   DIGIT_LEFT  : value of pmod[7] that selects the left / high-nibble digit
//   state_t     : arbiter FSM states
//   hex7_decode : nibble -> active-low segment pattern, bit 6..0
package dtpmod_pkg;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic       DIGIT_LEFT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    function automatic logic [6:0] hex7_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h02;
            4'h1:    seg = 7'h2F;
            4'h2:    seg = 7'h41;
            4'h3:    seg = 7'h05;
            4'h4:    seg = 7'h2C;
            4'h5:    seg = 7'h14;
            4'h6:    seg = 7'h10;
            4'h7:    seg = 7'h0F;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h0C;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h30;
            4'hC:    seg = 7'h71;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h50;
            4'hF:    seg = 7'h58;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/dtpmod_digit_driver.sv
// Digit multiplexer for the dual-digit DT PMOD display.
//   clk50    in  1  system clock
//   reset    in  1  asynchronous, active-high reset
//   blank    in  1  1 = force all segments off
//   byte_val in  8  byte to show, high nibble on the left digit
//   pmod     out 8  [7] digit select, [6:0] active-low segments (registered)
// A free-running refresh counter's MSB picks the digit. Digit select and
// segments leave the same register, so they always change together.
module dtpmod_digit_driver
    import dtpmod_pkg::*;
#(
    parameter int REFRESH_BITS = 9
) (
    input  logic       clk50,
    input  logic       reset,
    input  logic       blank,
    input  logic [7:0] byte_val,
    output logic [7:0] pmod
);

    localparam logic [REFRESH_BITS-1:0] REFRESH_ONE = REFRESH_BITS'(1'b1);

    logic [REFRESH_BITS-1:0] refresh_ctr_r;
    logic                    left_sel_s;
    logic [3:0]              nibble_s;
    logic [6:0]              seg_s;
    logic [7:0]              pmod_r;

    // Free-running refresh counter, wraps naturally at 2^REFRESH_BITS.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            refresh_ctr_r <= '0;
        end else begin
            refresh_ctr_r <= refresh_ctr_r + REFRESH_ONE;
        end
    end

    // Nibble select and segment decode for the currently selected digit.
    always_comb begin
        left_sel_s = refresh_ctr_r[REFRESH_BITS-1];
        nibble_s   = (left_sel_s == DIGIT_LEFT) ? byte_val[7:4] : byte_val[3:0];
        if (blank) begin
            seg_s = SEG_BLANK;
        end else begin
            seg_s = hex7_decode(nibble_s);
        end
    end

    // Output register: digit select and segments captured on one edge.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            pmod_r <= 8'h7F;
        end else begin
            pmod_r <= {left_sel_s, seg_s};
        end
    end

    assign pmod = pmod_r;

endmodule

// File: rtl/dtpmod_display_arbiter.sv
// Round-robin arbiter sharing one DT PMOD dual-digit display among NREQ
// byte sources. A granted byte is shown for HOLD_CYCLES, followed by a
// blank gap of GAP_CYCLES (skipped when 0).
//   clk50   in  1       system clock, 50 MHz
//   reset   in  1       asynchronous, active-high reset
//   req     in  NREQ    request per source, held until its ack
//   data    in  8*NREQ  byte of source i at data[8*i+7:8*i], sampled at grant
//   ack     out NREQ    one-cycle pulse during the last display cycle of a slot
//   busy    out 1       high while showing or in the gap
//   cur_src out 3       source being shown (valid while busy)
//   pmod    out 8       [7] digit select (1 = left), [6:0] active-low segments
module dtpmod_display_arbiter
    import dtpmod_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int HOLD_CYCLES  = 50_000_000,
    parameter int GAP_CYCLES   = 2_500_000,
    parameter int REFRESH_BITS = 9,
    parameter int PERSIST      = 0
) (
    input  logic              clk50,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] data,
    output logic [NREQ-1:0]   ack,
    output logic              busy,
    output logic [2:0]        cur_src,
    output logic [7:0]        pmod
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1'b1);
    localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1'b1);
    localparam logic              HAS_GAP   = (GAP_CYCLES > 0);
    localparam logic              KEEP_LAST = (PERSIST != 0);
    localparam logic [NREQ-1:0]   ACK_LSB   = NREQ'(1'b1);
    localparam logic [2:0]        PTR_LAST  = 3'(NREQ - 1);

    state_t              state_r, state_nxt_s;
    logic [2:0]          ptr_r, ptr_nxt_s;
    logic [HOLD_W-1:0]   hold_ctr_r, hold_nxt_s;
    logic [GAP_W-1:0]    gap_ctr_r, gap_nxt_s;
    logic [2:0]          cur_src_r, src_nxt_s;
    logic [7:0]          shown_byte_r, byte_nxt_s;
    logic                shown_valid_r, shown_valid_nxt_s;
    logic [NREQ-1:0]     ack_r, ack_nxt_s;
    logic                busy_r;

    logic [2*NREQ-1:0]   req_dbl_s;
    logic [NREQ-1:0]     req_rot_s;
    logic [3:0]          offs_s;
    logic [3:0]          sum_s;
    logic                grant_found_s;
    logic [2:0]          grant_idx_s;
    logic [8*NREQ-1:0]   data_shift_s;
    logic [7:0]          grant_byte_s;
    logic                blank_s;

    // Round-robin pick: rotate req so the pointer lands on bit 0, then take
    // the lowest set bit and rotate the offset back to a source index.
    always_comb begin
        req_dbl_s     = {req, req} >> ptr_r;
        req_rot_s     = req_dbl_s[NREQ-1:0];
        grant_found_s = |req_rot_s;
        offs_s        = 4'd0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            offs_s = req_rot_s[k] ? 4'(k) : offs_s;
        end
        sum_s        = {1'b0, ptr_r} + offs_s;
        grant_idx_s  = (sum_s >= 4'(NREQ)) ? 3'(sum_s - 4'(NREQ)) : sum_s[2:0];
        data_shift_s = data >> {grant_idx_s, 3'b000};
        grant_byte_s = data_shift_s[7:0];
    end

    // FSM next state, counters, grant capture and registered-output values.
    always_comb begin
        state_nxt_s       = state_r;
        ptr_nxt_s         = ptr_r;
        hold_nxt_s        = hold_ctr_r;
        gap_nxt_s         = gap_ctr_r;
        src_nxt_s         = cur_src_r;
        byte_nxt_s        = shown_byte_r;
        shown_valid_nxt_s = shown_valid_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_found_s) begin
                    state_nxt_s       = ST_SHOW;
                    src_nxt_s         = grant_idx_s;
                    byte_nxt_s        = grant_byte_s;
                    ptr_nxt_s         = (grant_idx_s == PTR_LAST) ? 3'd0 : grant_idx_s + 3'd1;
                    hold_nxt_s        = '0;
                    shown_valid_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHOW: begin
                if (hold_ctr_r == HOLD_LAST) begin
                    if (HAS_GAP) begin
                        state_nxt_s = ST_GAP;
                        gap_nxt_s   = '0;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    hold_nxt_s = hold_ctr_r + HOLD_ONE;
                end
            end
            ST_GAP: begin
                if (gap_ctr_r == GAP_LAST) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    gap_nxt_s = gap_ctr_r + GAP_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        // Ack is registered, so it is raised one edge early: it is high
        // exactly during the final SHOW cycle of the slot.
        ack_nxt_s = ((state_nxt_s == ST_SHOW) && (hold_nxt_s == HOLD_LAST))
                    ? (ACK_LSB << src_nxt_s) : '0;
    end

    // State, pointer, counters and registered outputs.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            ptr_r         <= 3'd0;
            hold_ctr_r    <= '0;
            gap_ctr_r     <= '0;
            cur_src_r     <= 3'd0;
            shown_byte_r  <= 8'h00;
            shown_valid_r <= 1'b0;
            ack_r         <= '0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            ptr_r         <= ptr_nxt_s;
            hold_ctr_r    <= hold_nxt_s;
            gap_ctr_r     <= gap_nxt_s;
            cur_src_r     <= src_nxt_s;
            shown_byte_r  <= byte_nxt_s;
            shown_valid_r <= shown_valid_nxt_s;
            ack_r         <= ack_nxt_s;
            busy_r        <= (state_nxt_s != ST_IDLE);
        end
    end

    // Display enable: always in SHOW; in IDLE only when persisting a byte
    // that was actually shown since reset.
    always_comb begin
        if (state_r == ST_SHOW) begin
            blank_s = 1'b0;
        end else if ((state_r == ST_IDLE) && KEEP_LAST && shown_valid_r) begin
            blank_s = 1'b0;
        end else begin
            blank_s = 1'b1;
        end
    end

    dtpmod_digit_driver #(
        .REFRESH_BITS(REFRESH_BITS)
    ) u_digit_driver (
        .clk50    (clk50),
        .reset    (reset),
        .blank    (blank_s),
        .byte_val (shown_byte_r),
        .pmod     (pmod)
    );

    assign ack     = ack_r;
    assign busy    = busy_r;
    assign cur_src = cur_src_r;

endmodule

// File: tb/tb_dtpmod_display_arbiter.sv
`timescale 1ns/1ps
module tb_dtpmod_display_arbiter;

    localparam int HOLD = 8;

    typedef struct packed {
        logic [2:0] src;
        logic [7:0] byte_v;
    } exp_t;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h02, 7'h2F, 7'h41, 7'h05, 7'h2C, 7'h14, 7'h10, 7'h0F,
        7'h00, 7'h0C, 7'h08, 7'h30, 7'h71, 7'h21, 7'h50, 7'h58
    };

    logic        clk50 = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = 4'd0, req_p = 4'd0;
    logic [31:0] data = 32'd0, data_p = 32'd0;
    logic [3:0]  ack, ack_p;
    logic        busy, busy_p;
    logic [2:0]  cur_src, cur_src_p;
    logic [7:0]  pmod, pmod_p;

    int   n_total = 0;
    int   n_pass  = 0;
    exp_t exp_q[$];

    int         busy_run = 0;
    logic       slot_bad = 1'b0;
    exp_t       mon_e;
    logic [3:0] mon_nib;
    logic [3:0] mon_exp_ack;

    always #10 clk50 = ~clk50;

    dtpmod_display_arbiter #(
        .NREQ(4), .HOLD_CYCLES(HOLD), .GAP_CYCLES(2), .REFRESH_BITS(3), .PERSIST(0)
    ) u_dut (
        .clk50(clk50), .reset(reset), .req(req), .data(data),
        .ack(ack), .busy(busy), .cur_src(cur_src), .pmod(pmod)
    );

    dtpmod_display_arbiter #(
        .NREQ(4), .HOLD_CYCLES(HOLD), .GAP_CYCLES(2), .REFRESH_BITS(3), .PERSIST(1)
    ) u_dut_p (
        .clk50(clk50), .reset(reset), .req(req_p), .data(data_p),
        .ack(ack_p), .busy(busy_p), .cur_src(cur_src_p), .pmod(pmod_p)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk50);
        reset = 1'b1;
        req   = 4'd0;
        req_p = 4'd0;
        exp_q.delete();
        repeat (2) @(negedge clk50);
        reset = 1'b0;
    endtask

    task automatic wait_acks(input int n, input int budget, input string name);
        int seen = 0;
        for (int c = 0; c < budget && seen < n; c++) begin
            @(negedge clk50);
            if (ack != 4'd0) seen++;
        end
        check(name, 32'(seen), 32'(n));
    endtask

    // Monitor: pops one expected slot per ack and checks slot contents.
    initial begin
        forever begin
            @(negedge clk50);
            if (reset) begin
                busy_run = 0;
                slot_bad = 1'b0;
            end else begin
                if (busy) busy_run++;
                else busy_run = 0;
                if (busy && busy_run >= 2 && busy_run <= HOLD) begin
                    if (exp_q.size() == 0) begin
                        slot_bad = 1'b1;
                    end else begin
                        mon_e   = exp_q[0];
                        mon_nib = pmod[7] ? mon_e.byte_v[7:4] : mon_e.byte_v[3:0];
                        if (pmod[6:0] !== SEG_TAB[mon_nib]) slot_bad = 1'b1;
                    end
                end
                if (ack != 4'd0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_ack", 32'(ack), 32'd0);
                    end else begin
                        mon_e       = exp_q.pop_front();
                        mon_exp_ack = 4'b0001 << mon_e.src;
                        check("ack_onehot", 32'(ack), 32'(mon_exp_ack));
                        check("cur_src", 32'(cur_src), 32'(mon_e.src));
                        check("slot_len", 32'(busy_run), 32'(HOLD));
                        check("slot_digits", 32'(slot_bad), 32'd0);
                        slot_bad = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bad_seg;
        int bad_dig;
        int cnt;
        logic exp_msb;

        // Test 1: reset values, then idle with no requests
        repeat (2) @(negedge clk50);
        check("rst_pmod", 32'(pmod), 32'h7F);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_cur_src", 32'(cur_src), 32'd0);
        check("rst_pmod_p", 32'(pmod_p), 32'h7F);
        reset = 1'b0;
        bad_seg = 0;
        bad_dig = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk50);
            if (pmod[6:0] !== 7'h7F || busy !== 1'b0 || ack !== 4'd0) bad_seg++;
            exp_msb = (((k - 1) / 4) % 2) == 1;
            if (pmod[7] !== exp_msb) bad_dig++;
        end
        check("t1_idle_blank", 32'(bad_seg), 32'd0);
        check("t1_refresh_toggle", 32'(bad_dig), 32'd0);

        // Test 2: single request, latency, gap
        reset_dut();
        data = 32'h0000_0010;
        req  = 4'b0001;
        exp_q.push_back('{src: 3'd0, byte_v: 8'h10});
        @(negedge clk50);
        check("t2_busy", 32'(busy), 32'd1);
        check("t2_lat_blank", 32'(pmod[6:0]), 32'h7F);
        @(negedge clk50);
        check("t2_lat_seg", 32'(pmod[6:0]), pmod[7] ? 32'h2F : 32'h02);
        wait_acks(1, 40, "t2_ack_count");
        req = 4'd0;
        @(negedge clk50);
        check("t2_gap_busy", 32'(busy), 32'd1);
        @(negedge clk50);
        check("t2_gap_blank", 32'(pmod[6:0]), 32'h7F);
        check("t2_gap_busy2", 32'(busy), 32'd1);
        @(negedge clk50);
        check("t2_idle", 32'(busy), 32'd0);
        repeat (4) @(negedge clk50);

        // Test 3: all four held, round-robin 0,1,2,3,0
        reset_dut();
        data = 32'h3C5B_E794;
        exp_q.push_back('{src: 3'd0, byte_v: 8'h94});
        exp_q.push_back('{src: 3'd1, byte_v: 8'hE7});
        exp_q.push_back('{src: 3'd2, byte_v: 8'h5B});
        exp_q.push_back('{src: 3'd3, byte_v: 8'h3C});
        exp_q.push_back('{src: 3'd0, byte_v: 8'h94});
        req = 4'b1111;
        wait_acks(5, 90, "t3_ack_count");
        req = 4'd0;
        repeat (12) @(negedge clk50);

        // Test 4: src 2 requests mid-slot of src 0; src 0 drops its req early
        reset_dut();
        data = 32'h00A6_0021;
        exp_q.push_back('{src: 3'd0, byte_v: 8'h21});
        exp_q.push_back('{src: 3'd2, byte_v: 8'hA6});
        req = 4'b0001;
        repeat (3) @(negedge clk50);
        req = 4'b0100;
        wait_acks(2, 60, "t4_ack_count");
        req = 4'd0;
        repeat (12) @(negedge clk50);

        // Test 5: reset at SHOW cycle 4 aborts the slot
        reset_dut();
        data = 32'h0000_00C3;
        exp_q.push_back('{src: 3'd0, byte_v: 8'hC3});
        req = 4'b0001;
        repeat (4) @(negedge clk50);
        check("t5_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_pmod", 32'(pmod), 32'h7F);
        check("t5_rst_ack", 32'(ack), 32'd0);
        check("t5_rst_cur_src", 32'(cur_src), 32'd0);
        exp_q.delete();
        req = 4'd0;
        repeat (2) @(negedge clk50);
        reset = 1'b0;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk50);
            if (ack != 4'd0) cnt++;
        end
        check("t5_no_ack", 32'(cnt), 32'd0);
        data = 32'h4000_0059;
        exp_q.push_back('{src: 3'd0, byte_v: 8'h59});
        req = 4'b1001;
        wait_acks(1, 40, "t5_regrant_count");
        req = 4'd0;
        repeat (12) @(negedge clk50);

        // Test 6: PERSIST=1 keeps showing 8'hAF in IDLE
        reset_dut();
        data_p = 32'h0000_00AF;
        req_p  = 4'b0001;
        cnt = 0;
        for (int c = 0; c < 40 && cnt == 0; c++) begin
            @(negedge clk50);
            if (ack_p != 4'd0) cnt++;
        end
        check("t6_ack_seen", 32'(cnt), 32'd1);
        check("t6_ack_value", 32'(ack_p), 32'h1);
        check("t6_cur_src", 32'(cur_src_p), 32'd0);
        req_p = 4'd0;
        repeat (2) @(negedge clk50);
        check("t6_gap_blank", 32'(pmod_p[6:0]), 32'h7F);
        repeat (4) @(negedge clk50);
        bad_seg = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk50);
            if (busy_p !== 1'b0) bad_seg++;
            if (pmod_p[6:0] !== (pmod_p[7] ? 7'h08 : 7'h58)) bad_seg++;
        end
        check("t6_persist", 32'(bad_seg), 32'd0);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
